bullet_writer: RTL and testbench

Owns the bullet object table and is its writer: accepts spawn requests, advances every live bullet by its velocity once per frame tick, and retires bullets that leave the play field. It exposes the same index-addressed read port (position, size, color, isRender) that the renderer already consumes, so it drops in as the table source between game logic and the VGA render path.

---
 rtl/bullet_pkg.sv | 44 ++++
 rtl/bullet_mover.sv | 58 +++++
 rtl/bullet_writer.sv | 171 +++++++++++++++++
 tb/tb_bullet_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// -----------------------------------------------------------------------------
// bullet_pkg
// Shared definitions for the bullet table writer:
//   - bit offsets and widths of the 64-bit bullet entry
//   - FSM state enum (IDLE / SWEEP)
//   - default play-field limits XMAX_DEFAULT / YMAX_DEFAULT
//   - coord_step(): coordinate + signed velocity, with guard bits
// -----------------------------------------------------------------------------
package bullet_pkg;

   localparam int ENTRY_W   = 64;
   localparam int COORD_W   = 8;
   localparam int COLOR_W   = 2;

   // Entry layout: [7:0] y, [15:8] x, [23:16] ysize, [31:24] xsize,
   // [33:32] color, [34] live, [42:35] vx, [50:43] vy, [63:51] zero.
   localparam int Y_LSB     = 0;
   localparam int X_LSB     = 8;
   localparam int YSIZE_LSB = 16;
   localparam int XSIZE_LSB = 24;
   localparam int COLOR_LSB = 32;
   localparam int LIVE_BIT  = 34;
   localparam int VX_LSB    = 35;
   localparam int VY_LSB    = 43;

   localparam logic [COORD_W-1:0] XMAX_DEFAULT = 8'd159;
   localparam logic [COORD_W-1:0] YMAX_DEFAULT = 8'd119;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // Unsigned coordinate plus two's-complement velocity. Two guard bits
   // above the 8-bit coordinate keep the sum exact for any spawn value
   // (0..255 plus -128..127), so a large step never aliases into range.
   function automatic logic signed [COORD_W+1:0] coord_step(
      input logic [COORD_W-1:0] pos,
      input logic [COORD_W-1:0] vel
   );
      return $signed({2'b00, pos}) + $signed({{2{vel[COORD_W-1]}}, vel});
   endfunction

endpackage

// File: rtl/bullet_mover.sv
// -----------------------------------------------------------------------------
// bullet_mover
// Purely combinational next-state for one bullet entry: adds velocity to a
// live entry and either retires it when it leaves the field, or (with the
// BULLET_WRAP_EN macro defined) wraps it modulo the field. Dead entries pass
// through unchanged.
// Ports:
//   entry      in   current 64-bit entry
//   xmax/ymax  in   largest legal x / y coordinate
//   next_entry out  entry after one movement step
// -----------------------------------------------------------------------------
module bullet_mover
   import bullet_pkg::*;
(
   input  logic [ENTRY_W-1:0] entry,
   input  logic [COORD_W-1:0] xmax,
   input  logic [COORD_W-1:0] ymax,
   output logic [ENTRY_W-1:0] next_entry
);

   logic signed [COORD_W+1:0] nx, ny;
   logic signed [COORD_W+1:0] lim_x, lim_y;
   logic                      x_lo, x_hi, y_lo, y_hi;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      next_entry = entry;
      nx    = coord_step(entry[X_LSB +: COORD_W], entry[VX_LSB +: COORD_W]);
      ny    = coord_step(entry[Y_LSB +: COORD_W], entry[VY_LSB +: COORD_W]);
      lim_x = $signed({2'b00, xmax});
      lim_y = $signed({2'b00, ymax});
      x_lo  = nx < 0;
      x_hi  = nx > lim_x;
      y_lo  = ny < 0;
      y_hi  = ny > lim_y;

      if (entry[LIVE_BIT]) begin
`ifdef BULLET_WRAP_EN
         if (x_lo)      nx = nx + lim_x + 10'sd1;
         else if (x_hi) nx = nx - (lim_x + 10'sd1);
         if (y_lo)      ny = ny + lim_y + 10'sd1;
         else if (y_hi) ny = ny - (lim_y + 10'sd1);
         next_entry[X_LSB +: COORD_W] = nx[COORD_W-1:0];
         next_entry[Y_LSB +: COORD_W] = ny[COORD_W-1:0];
`else
         // Leaving the field retires the bullet with its position frozen.
         if (x_lo || x_hi || y_lo || y_hi) begin
            next_entry[LIVE_BIT] = 1'b0;
         end else begin
            next_entry[X_LSB +: COORD_W] = nx[COORD_W-1:0];
            next_entry[Y_LSB +: COORD_W] = ny[COORD_W-1:0];
         end
`endif
      end
   end

endmodule

// File: rtl/bullet_writer.sv
// -----------------------------------------------------------------------------
// bullet_writer
// Owns the bullet object table: accepts spawns into the lowest free slot,
// sweeps every entry once per frame_tick (one entry per cycle), retires or
// wraps bullets via bullet_mover, and serves a 1-cycle registered read port.
// Optional feature macro: BULLET_WRAP_EN (wrap instead of retire).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse that starts a movement sweep
//   spawn_valid/ready spawn handshake; spawn_pos/size/vel/color = payload
//   index             read address; position/size/color/isRender = entry
//   sweep_done        high during the last sweep cycle
//   live_count        number of live entries
// -----------------------------------------------------------------------------
module bullet_writer
   import bullet_pkg::*;
#(
   parameter int                 NUM_BULLETS = 8,
   parameter logic [COORD_W-1:0] XMAX        = XMAX_DEFAULT,
   parameter logic [COORD_W-1:0] YMAX        = YMAX_DEFAULT
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         frame_tick,
   input  logic         spawn_valid,
   output logic         spawn_ready,
   input  logic [15:0]  spawn_pos,
   input  logic [15:0]  spawn_size,
   input  logic [15:0]  spawn_vel,
   input  logic [1:0]   spawn_color,
   input  logic [3:0]   index,
   output logic [15:0]  position,
   output logic [15:0]  size,
   output logic [2:0]   color,
   output logic         isRender,
   output logic         sweep_done,
   output logic [4:0]   live_count
);

   localparam int PTR_W = $clog2(NUM_BULLETS);

   logic [ENTRY_W-1:0] bullet_tbl [NUM_BULLETS];
   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q;
   logic               tick_pending_q;
   logic               last_entry, sweep_active, spawn_fire, retire;
   logic               free_found;
   logic [PTR_W-1:0]   free_idx;
   logic [ENTRY_W-1:0] cur_entry, moved_entry, spawn_entry, rd_entry;

   assign last_entry = (ptr_q == PTR_W'(NUM_BULLETS - 1));
   assign cur_entry  = bullet_tbl[ptr_q];

   bullet_mover u_mover (
      .entry      (cur_entry),
      .xmax       (XMAX),
      .ymax       (YMAX),
      .next_entry (moved_entry)
   );

   // Lowest-index dead entry; scanning downward lets the lowest one win.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (!bullet_tbl[i][LIVE_BIT]) begin
            free_found = 1'b1;
            free_idx   = PTR_W'(i);
         end
      end
   end

   always_comb begin
      spawn_entry                             = '0;
      spawn_entry[Y_LSB     +: COORD_W]       = spawn_pos[7:0];
      spawn_entry[X_LSB     +: COORD_W]       = spawn_pos[15:8];
      spawn_entry[YSIZE_LSB +: COORD_W]       = spawn_size[7:0];
      spawn_entry[XSIZE_LSB +: COORD_W]       = spawn_size[15:8];
      spawn_entry[COLOR_LSB +: COLOR_W]       = spawn_color;
      spawn_entry[LIVE_BIT]                   = 1'b1;
      spawn_entry[VX_LSB    +: COORD_W]       = spawn_vel[15:8];
      spawn_entry[VY_LSB    +: COORD_W]       = spawn_vel[7:0];
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples
      // the pre-edge values; blocking here would create order-dependent races.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // A tick seen during the last sweep cycle (or one already pending) chains
   // straight into a new sweep instead of passing through IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (frame_tick || tick_pending_q) state_d = SWEEP;
         SWEEP:   if (last_entry) state_d = (frame_tick || tick_pending_q) ? SWEEP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // rst_n gates spawn_ready so no transfer can be seen while in reset.
   always_comb begin
      sweep_active = (state_q == SWEEP);
      sweep_done   = sweep_active && last_entry;
      spawn_ready  = rst_n && (state_q == IDLE) && !frame_tick && free_found;
   end

   assign spawn_fire = spawn_valid && spawn_ready;
   assign retire     = sweep_active && cur_entry[LIVE_BIT] && !moved_entry[LIVE_BIT];

   // ---------------- sweep pointer, tick pending, live count ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= '0;
         tick_pending_q <= 1'b0;
         live_count     <= '0;
      end else begin
         if (sweep_active && !last_entry) ptr_q <= ptr_q + 1'b1;
         else                             ptr_q <= '0;

         // Pending ticks collapse into one; consumed when the sweep ends.
         if (sweep_active) begin
            if (last_entry)      tick_pending_q <= 1'b0;
            else if (frame_tick) tick_pending_q <= 1'b1;
         end

         // Spawn (IDLE only) and retirement (SWEEP only) never coincide.
         if (spawn_fire)  live_count <= live_count + 5'd1;
         else if (retire) live_count <= live_count - 5'd1;
      end
   end

   // ---------------- bullet table ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the table is a small flop array that must read as all-dead right
      // after reset, so it is cleared here; a RAM-style memory would not be.
      if (!rst_n) begin
         for (int i = 0; i < NUM_BULLETS; i++) bullet_tbl[i] <= '0;
      end else if (sweep_active) begin
         bullet_tbl[ptr_q] <= moved_entry;
      end else if (spawn_fire) begin
         bullet_tbl[free_idx] <= spawn_entry;
      end
   end

   // ---------------- registered read port ----------------
   always_comb begin
      rd_entry = '0;
      if (int'(index) < NUM_BULLETS) rd_entry = bullet_tbl[index[PTR_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position <= '0;
         size     <= '0;
         color    <= '0;
         isRender <= 1'b0;
      end else begin
         position <= {rd_entry[X_LSB +: COORD_W], rd_entry[Y_LSB +: COORD_W]};
         size     <= {rd_entry[XSIZE_LSB +: COORD_W], rd_entry[YSIZE_LSB +: COORD_W]};
         color    <= {1'b0, rd_entry[COLOR_LSB +: COLOR_W]};
         isRender <= rd_entry[LIVE_BIT];
      end
   end

endmodule

// File: tb/tb_bullet_writer.sv
// -----------------------------------------------------------------------------
// tb_bullet_writer
// Directed self-checking bench for bullet_writer (NUM_BULLETS = 8). Expected
// values are hand-computed; expectations that differ when BULLET_WRAP_EN is
// defined are selected with the same macro.
// -----------------------------------------------------------------------------
module tb_bullet_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick;
   logic        spawn_valid;
   logic        spawn_ready;
   logic [15:0] spawn_pos, spawn_size, spawn_vel;
   logic [1:0]  spawn_color;
   logic [3:0]  index;
   logic [15:0] position, size;
   logic [2:0]  color;
   logic        isRender;
   logic        sweep_done;
   logic [4:0]  live_count;

   int checks = 0;
   int errors = 0;

   bullet_writer #(.NUM_BULLETS(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .spawn_valid (spawn_valid),
      .spawn_ready (spawn_ready),
      .spawn_pos   (spawn_pos),
      .spawn_size  (spawn_size),
      .spawn_vel   (spawn_vel),
      .spawn_color (spawn_color),
      .index       (index),
      .position    (position),
      .size        (size),
      .color       (color),
      .isRender    (isRender),
      .sweep_done  (sweep_done),
      .live_count  (live_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] rd_exp(input logic [15:0] pos, input logic [15:0] sz,
                                          input logic [2:0] col, input logic live);
      return {pos, sz, col, live};
   endfunction

   task automatic rd(input logic [3:0] idx, output logic [35:0] v);
      index = idx;
      step();
      v = {position, size, color, isRender};
   endtask

   task automatic spawn(input logic [15:0] pos, input logic [15:0] sz,
                        input logic [15:0] vel, input logic [1:0] col);
      int n;
      spawn_pos = pos; spawn_size = sz; spawn_vel = vel; spawn_color = col;
      spawn_valid = 1'b1;
      #1;
      n = 0;
      while (!spawn_ready && n < 40) begin
         step();
         n++;
      end
      check("spawn_ready_in_time", spawn_ready, 1'b1);
      step();
      spawn_valid = 1'b0;
   endtask

   // Pulses frame_tick for one cycle; n = cycles from the tick to sweep_done.
   task automatic tick_wait(output int n);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n = 1;
      while (!sweep_done && n < 40) begin
         step();
         n++;
      end
   endtask

   logic [35:0] v;
   int          n, first_done, second_done, ndone;
   logic [4:0]  saved_count;

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0;
      spawn_pos = '0; spawn_size = '0; spawn_vel = '0; spawn_color = '0;
      index = '0;

      // ---------------- reset ----------------
      repeat (3) step();
      check("rst_ready", spawn_ready, 1'b0);
      check("rst_done", sweep_done, 1'b0);
      check("rst_count", live_count, 5'd0);
      check("rst_outputs", {position, size, color, isRender}, 36'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", spawn_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         rd(4'(i), v);
         check("rst_entry", v, 36'd0);
      end

      // ---------------- first spawn ----------------
      spawn(16'h0A14, 16'h0404, 16'h03FE, 2'd2);
      rd(4'd0, v);
      check("spawn_read", v, rd_exp(16'h0A14, 16'h0404, 3'd2, 1'b1));
      check("spawn_count", live_count, 5'd1);

      // ---------------- first sweep ----------------
      tick_wait(n);
      check("sweep_len", n, 8);
      step();
      check("idle_after_sweep", spawn_ready, 1'b1);
      rd(4'd0, v);
      check("move_a", v, rd_exp(16'h0D12, 16'h0404, 3'd2, 1'b1));

      // ---------------- right-edge bullet ----------------
      spawn(16'h9E32, 16'h0202, 16'h0300, 2'd1);
      check("spawn_b_count", live_count, 5'd2);
      tick_wait(n);
      check("sweep_len_b", n, 8);
      step();
      rd(4'd1, v);
`ifdef BULLET_WRAP_EN
      check("edge_wrap", v, rd_exp(16'h0132, 16'h0202, 3'd1, 1'b1));
      check("edge_count", live_count, 5'd2);
`else
      check("edge_retire", v, rd_exp(16'h9E32, 16'h0202, 3'd1, 1'b0));
      check("edge_count", live_count, 5'd1);
`endif
      rd(4'd0, v);
      check("move_a2", v, rd_exp(16'h1010, 16'h0404, 3'd2, 1'b1));

      // ---------------- tick beats spawn, pending ticks ----------------
      saved_count = live_count;
      spawn_pos = 16'h5050; spawn_size = 16'h0101; spawn_vel = 16'h0000; spawn_color = 2'd1;
      spawn_valid = 1'b1;
      frame_tick  = 1'b1;
      #1;
      check("tick_beats_spawn", spawn_ready, 1'b0);
      step();
      spawn_valid = 1'b0;
      ndone = 0; first_done = 0; second_done = 0;
      for (int c = 1; c <= 24; c++) begin
         frame_tick = (c == 2 || c == 5);
         if (sweep_done) begin
            ndone++;
            if (ndone == 1) first_done = c;
            if (ndone == 2) second_done = c;
         end
         step();
      end
      frame_tick = 1'b0;
      check("pending_sweeps", ndone, 2);
      check("first_done_cycle", first_done, 8);
      check("second_done_cycle", second_done, 16);
      check("no_spawn_on_tick", live_count, saved_count);
      rd(4'd0, v);
      check("move_a4", v, rd_exp(16'h160C, 16'h0404, 3'd2, 1'b1));

      // ---------------- fill the table ----------------
      spawn(16'h0000, 16'h0101, 16'hFF00, 2'd0);
      for (int k = 0; k < 10 && live_count < 5'd8; k++) begin
         spawn({8'(30 + k), 8'd100}, 16'h0101, 16'h0000, 2'd1);
      end
      check("full_count", live_count, 5'd8);
      check("full_not_ready", spawn_ready, 1'b0);
      rd(4'd9, v);
      check("oob_index9", v, 36'd0);
      rd(4'd15, v);
      check("oob_index15", v, 36'd0);

      // 9th spawn is held until a retirement frees a slot.
      spawn_pos = 16'h2828; spawn_size = 16'h0101; spawn_vel = 16'h0000; spawn_color = 2'd3;
      spawn_valid = 1'b1;
      step();
      step();
      check("held_while_full", live_count, 5'd8);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n = 1;
      while (!sweep_done && n < 40) begin
         step();
         n++;
      end
      check("sweep_len_full", n, 8);
      step();
`ifdef BULLET_WRAP_EN
      check("wrap_still_full", spawn_ready, 1'b0);
      step();
      spawn_valid = 1'b0;
      check("wrap_count", live_count, 5'd8);
      rd(4'd1, v);
      check("wrap_b", v, rd_exp(16'h0A32, 16'h0202, 3'd1, 1'b1));
      rd(4'd2, v);
      check("wrap_left", v, rd_exp(16'h9F00, 16'h0101, 3'd0, 1'b1));
`else
      check("freed_count", live_count, 5'd7);
      check("freed_ready", spawn_ready, 1'b1);
      step();
      spawn_valid = 1'b0;
      check("refill_count", live_count, 5'd8);
      rd(4'd1, v);
      check("refill_slot", v, rd_exp(16'h2828, 16'h0101, 3'd3, 1'b1));
`endif
      rd(4'd0, v);
      check("move_a5", v, rd_exp(16'h190A, 16'h0404, 3'd2, 1'b1));

      // ---------------- reset mid-sweep ----------------
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_count", live_count, 5'd0);
      check("midrst_ready", spawn_ready, 1'b0);
      check("midrst_done", sweep_done, 1'b0);
      check("midrst_outputs", {position, size, color, isRender}, 36'd0);
      step();
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (sweep_done) ndone++;
         step();
      end
      check("midrst_no_done", ndone, 0);
      rd(4'd0, v);
      check("midrst_entry0", v, 36'd0);
      rd(4'd1, v);
      check("midrst_entry1", v, 36'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
